// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - instruction fetch sequencer owning the program counter
//
// Purpose: holds the PC and issues one imem request at a time. The fetched
// word is buffered toward decode. Redirects are applied with the priority
// trap > branch/jump > sequential PC+4.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   imem_req_valid/ready/addr        fetch request handshake, addr = pc
//   imem_resp_valid/data             one response word per accepted request
//   if_valid/ready, if_instr, if_pc  instruction buffer toward decode
//   redirect_valid, redirect_target  taken branch/jump from the ALU
//   trap_valid                       exception/interrupt redirect
//   fetch_misaligned                 1-cycle pulse after a misaligned redirect
//   fetch_count                      number of decode handshakes (wraps)
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        trap_valid,
   output logic        fetch_misaligned,
   output logic [31:0] fetch_count
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        kill_q, kill_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ipc_q, ipc_d;
   logic        mis_q, mis_d;
   logic [31:0] cnt_q, cnt_d;

   logic        req_hs;
   logic        if_hs;
   logic        active;
   logic        redir;
   logic        target_misaligned;
   logic [31:0] redir_pc;

   assign req_hs            = (state_q == S_REQ) && imem_req_ready;
   assign if_hs             = (state_q == S_OUT) && if_ready;
   assign active            = (state_q != S_IDLE);
   assign redir             = active && (trap_valid || redirect_valid);
   // A trap wins, so a misaligned branch target alongside a trap is not flagged.
   assign target_misaligned = !trap_valid && redirect_valid && (redirect_target[1:0] != 2'b00);
   assign redir_pc          = (trap_valid || target_misaligned) ? TRAP_VECTOR : redirect_target;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_VECTOR;
         kill_q  <= 1'b0;
         instr_q <= NOP;
         ipc_q   <= RESET_VECTOR;
         mis_q   <= 1'b0;
         cnt_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         kill_q  <= kill_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         mis_q   <= mis_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      kill_d  = kill_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      mis_d   = active && target_misaligned;
      cnt_d   = cnt_q;

      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (req_hs) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (imem_resp_valid) begin
               if (kill_q) begin
                  // Response belongs to an abandoned request: drop it and refetch.
                  kill_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  instr_d = imem_resp_data;
                  ipc_d   = pc_q;
                  state_d = S_OUT;
               end
            end
         end
         S_OUT: begin
            if (if_hs) begin
               pc_d    = pc_q + 32'd4;
               cnt_d   = cnt_q + 32'd1;
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Redirect overrides everything above; the buffered word and any
      // decode handshake this cycle are discarded.
      if (redir) begin
         pc_d    = redir_pc;
         cnt_d   = cnt_q;
         instr_d = instr_q;
         ipc_d   = ipc_q;
         case (state_q)
            S_REQ: begin
               // An accepted request still owes a response; mark it for dropping.
               state_d = req_hs ? S_WAIT : S_REQ;
               kill_d  = req_hs;
            end
            S_WAIT: begin
               if (imem_resp_valid) begin
                  state_d = S_REQ;
                  kill_d  = 1'b0;
               end else begin
                  state_d = S_WAIT;
                  kill_d  = 1'b1;
               end
            end
            S_OUT:   state_d = S_REQ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign imem_req_valid   = (state_q == S_REQ);
   assign imem_req_addr    = pc_q;
   assign if_valid         = (state_q == S_OUT);
   assign if_instr         = instr_q;
   assign if_pc            = ipc_q;
   assign fetch_misaligned = mis_q;
   assign fetch_count      = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - randomized self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        trap_valid;
   logic        fetch_misaligned;
   logic [31:0] fetch_count;

   localparam logic [31:0] TRAP = 32'h0000_0100;

   pc_fetch_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .imem_req_valid   (imem_req_valid),
      .imem_req_ready   (imem_req_ready),
      .imem_req_addr    (imem_req_addr),
      .imem_resp_valid  (imem_resp_valid),
      .imem_resp_data   (imem_resp_data),
      .if_valid         (if_valid),
      .if_ready         (if_ready),
      .if_instr         (if_instr),
      .if_pc            (if_pc),
      .redirect_valid   (redirect_valid),
      .redirect_target  (redirect_target),
      .trap_valid       (trap_valid),
      .fetch_misaligned (fetch_misaligned),
      .fetch_count      (fetch_count)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Transaction-level model: one request may be outstanding, one word may be
   // buffered; any redirect poisons the outstanding request and empties the buffer.
   logic        m_idle;
   logic        m_out;
   logic        m_poison;
   int          m_dly;
   logic        m_buf;
   logic [31:0] m_bdata;
   logic [31:0] m_bpc;
   logic [31:0] m_pc;
   logic [31:0] m_reqpc;
   logic [31:0] m_cnt;
   logic        m_mis;
   int          max_dly = 0;
   logic [31:0] hs_addrs[$];

   task automatic model_reset();
      m_idle = 1'b1; m_out = 1'b0; m_poison = 1'b0; m_dly = 0;
      m_buf = 1'b0; m_bdata = 32'h0000_0013; m_bpc = 32'd0;
      m_pc = 32'd0; m_reqpc = 32'd0; m_cnt = 32'd0; m_mis = 1'b0;
   endtask

   // Called at a falling edge: drive one cycle of inputs, check, advance model.
   task automatic step(input logic rdy, input logic ifr, input logic rv,
                       input logic [31:0] tgt, input logic tv);
      logic        resp;
      logic        exp_req;
      logic        req_hs;
      logic        if_hs;
      logic        redir;
      logic [31:0] rdata;
      logic [31:0] t;
      resp  = m_out && (m_dly == 0);
      rdata = $urandom;
      imem_req_ready  = rdy;
      if_ready        = ifr;
      redirect_valid  = rv;
      redirect_target = tgt;
      trap_valid      = tv;
      imem_resp_valid = resp;
      imem_resp_data  = rdata;
      #1;
      exp_req = !m_idle && !m_out && !m_buf;
      check_eq("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
      if (exp_req) check_eq("req_addr", imem_req_addr, m_pc);
      check_eq("if_valid", {31'd0, if_valid}, {31'd0, m_buf});
      if (m_buf) begin
         check_eq("if_instr", if_instr, m_bdata);
         check_eq("if_pc", if_pc, m_bpc);
      end
      check_eq("fetch_count", fetch_count, m_cnt);
      check_eq("misaligned", {31'd0, fetch_misaligned}, {31'd0, m_mis});
      if (imem_req_valid && rdy) hs_addrs.push_back(imem_req_addr);

      req_hs = exp_req && rdy;
      if_hs  = m_buf && ifr;
      redir  = !m_idle && (rv || tv);
      if (tv) t = TRAP;
      else if (tgt[1:0] != 2'b00) t = TRAP;
      else t = tgt;
      m_mis = !m_idle && rv && !tv && (tgt[1:0] != 2'b00);

      if (resp) m_out = 1'b0;
      else if (m_out) m_dly--;
      if (redir) begin
         if (resp == 1'b0 && m_out) m_poison = 1'b1;
         m_buf = 1'b0;
         m_pc  = t;
         if (req_hs) begin
            m_out = 1'b1; m_poison = 1'b1; m_dly = $urandom_range(0, max_dly);
         end
      end else begin
         if (if_hs) begin
            m_buf = 1'b0; m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
         end
         if (resp && !m_poison) begin
            m_buf = 1'b1; m_bdata = rdata; m_bpc = m_reqpc;
         end
         if (req_hs) begin
            m_out = 1'b1; m_poison = 1'b0; m_reqpc = m_pc;
            m_dly = $urandom_range(0, max_dly);
         end
      end
      m_idle = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
      check_eq({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
      check_eq({tag, "_if_instr"}, if_instr, 32'h0000_0013);
      check_eq({tag, "_if_pc"}, if_pc, 32'd0);
      check_eq({tag, "_addr"}, imem_req_addr, 32'd0);
      check_eq({tag, "_count"}, fetch_count, 32'd0);
      check_eq({tag, "_mis"}, {31'd0, fetch_misaligned}, 32'd0);
   endtask

   initial begin
      logic [31:0] tgt;
      rst = 1'b1;
      imem_req_ready = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0;
      redirect_target = 32'd0; trap_valid = 1'b0;
      imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      // 1: straight-line fetch with a 1-cycle imem and an always-ready decode
      hs_addrs.delete();
      for (int i = 0; i < 13; i++) step(1, 1, 0, 0, 0);
      check_eq("t1_addr0", hs_addrs[0], 32'h0);
      check_eq("t1_addr1", hs_addrs[1], 32'h4);
      check_eq("t1_addr2", hs_addrs[2], 32'h8);
      check_eq("t1_addr3", hs_addrs[3], 32'hC);
      check_eq("t1_count", fetch_count, 32'd4);

      // 2: decode stalls for 5 cycles while a word is buffered
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         check_eq("t2_if_pc", if_pc, 32'h10);
         step(1, 0, 0, 0, 0);
      end
      check_eq("t2_if_pc_end", if_pc, 32'h10);
      step(1, 1, 0, 0, 0);
      check_eq("t2_count", fetch_count, 32'd5);

      // 3: branch while a fetch is in flight
      step(1, 0, 0, 0, 0);
      step(1, 0, 1, 32'h40, 0);
      check_eq("t3_addr", imem_req_addr, 32'h40);
      check_eq("t3_if_valid", {31'd0, if_valid}, 32'd0);

      // 4: trap wins over a simultaneous branch
      step(0, 0, 1, 32'h80, 1);
      check_eq("t4_addr", imem_req_addr, 32'h100);

      // 5: misaligned branch target
      step(0, 0, 1, 32'h200, 0);
      check_eq("t5_pre_addr", imem_req_addr, 32'h200);
      step(0, 0, 1, 32'h42, 0);
      check_eq("t5_mis", {31'd0, fetch_misaligned}, 32'd1);
      check_eq("t5_addr", imem_req_addr, 32'h100);
      step(0, 0, 0, 0, 0);
      check_eq("t5_mis_clear", {31'd0, fetch_misaligned}, 32'd0);

      // 6: reset while waiting, stale response arrives during reset
      step(1, 0, 0, 0, 0);
      rst = 1'b1;
      imem_req_ready = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data = 32'hDEAD_BEEF;
      #1;
      check_reset_outputs("t6_async");
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("t6_held");
      rst = 1'b0;
      imem_resp_valid = 1'b0;
      model_reset();
      hs_addrs.delete();
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
      check_eq("t6_first_addr", hs_addrs[0], 32'h0);
      check_eq("t6_if_pc", if_pc, 32'h0);
      step(1, 1, 0, 0, 0);

      // Randomized traffic with variable imem latency, stalls and redirects
      max_dly = 2;
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 3))
            0:       tgt = $urandom & 32'h0000_0FFC;
            1:       tgt = 32'hFFFF_FFF0 | ($urandom & 32'hC);
            2:       tgt = $urandom;
            default: tgt = $urandom & 32'h0000_00FC;
         endcase
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 9) == 0, tgt, $urandom_range(0, 29) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
